// File: rtl/alu_op_issuer_if.sv
// Request/response channel between the datapath control unit and alu_op_issuer.
// Optional result flags (rsp_zero, rsp_neg) exist only when ALU_OP_ISSUER_FLAGS_EN is defined.
interface alu_op_issuer_if #(
    parameter int BITS = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      req_op;
    logic [BITS-1:0] req_x;
    logic [BITS-1:0] req_y;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [BITS-1:0] rsp_hi;
    logic [BITS-1:0] rsp_lo;
    logic            rsp_err;
`ifdef ALU_OP_ISSUER_FLAGS_EN
    logic            rsp_zero;
    logic            rsp_neg;
`endif

    modport master (
        output req_valid, req_op, req_x, req_y, rsp_ready,
`ifdef ALU_OP_ISSUER_FLAGS_EN
        input  rsp_zero, rsp_neg,
`endif
        input  req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_x, req_y, rsp_ready,
`ifdef ALU_OP_ISSUER_FLAGS_EN
        output rsp_zero, rsp_neg,
`endif
        output req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err
    );
endinterface

// File: rtl/alu_op_issuer.sv
// Issues one op at a time to the combinational ALU, waits its settle time, returns {HI,LO}.
// Define ALU_OP_ISSUER_FLAGS_EN to add registered rsp_zero/rsp_neg result flags.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// EXEC  | alu_ctrl one-hot, counting down the op's settle time
// DONE  | response held on rsp_* until rsp_ready
module alu_op_issuer #(
    parameter int BITS           = 32,
    parameter int SIG_COUNT      = 12,
    parameter int ALU_LATENCY    = 1,
    parameter int MULDIV_LATENCY = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    alu_op_issuer_if.slave       bus,
    output logic [SIG_COUNT-1:0] alu_ctrl,
    output logic [BITS-1:0]      alu_x,
    output logic [BITS-1:0]      alu_y,
    input  logic [BITS-1:0]      alu_hi,
    input  logic [BITS-1:0]      alu_lo
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] ALU_LAT    = 4'(ALU_LATENCY);
    localparam logic [3:0] MULDIV_LAT = 4'(MULDIV_LATENCY);
    localparam logic [3:0] OP_MUL     = 4'd2;
    localparam logic [3:0] OP_DIV     = 4'd3;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [SIG_COUNT-1:0]  ctrl_d;
    logic [BITS-1:0]       x_d, y_d;
    logic [BITS-1:0]       hi_q, hi_d, lo_q, lo_d;
    logic                  err_q, err_d;
    logic                  zero_q, zero_d, neg_q, neg_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = alu_ctrl;
        x_d     = alu_x;
        y_d     = alu_y;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    x_d = bus.req_x;
                    y_d = bus.req_y;
                    if (int'(bus.req_op) < SIG_COUNT) begin
                        ctrl_d  = SIG_COUNT'(1) << bus.req_op;
                        cnt_d   = (bus.req_op == OP_MUL || bus.req_op == OP_DIV) ? MULDIV_LAT : ALU_LAT;
                        state_d = EXEC;
                    end else begin
                        ctrl_d  = '0;
                        hi_d    = '0;
                        lo_d    = '0;
                        err_d   = 1'b1;
                        zero_d  = 1'b0;
                        neg_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 4'd1) begin
                    hi_d    = alu_hi;
                    lo_d    = alu_lo;
                    err_d   = 1'b0;
                    zero_d  = (alu_hi == '0) && (alu_lo == '0);
                    neg_d   = alu_hi[BITS-1];
                    ctrl_d  = '0;
                    cnt_d   = 4'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            alu_ctrl <= '0;
            alu_x    <= '0;
            alu_y    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_ctrl <= ctrl_d;
            alu_x    <= x_d;
            alu_y    <= y_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            err_q    <= err_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_hi    = hi_q;
    assign bus.rsp_lo    = lo_q;
    assign bus.rsp_err   = err_q;
`ifdef ALU_OP_ISSUER_FLAGS_EN
    assign bus.rsp_zero  = zero_q;
    assign bus.rsp_neg   = neg_q;
`else
    // Flag registers are kept so both builds share one next-state block; they fold away here.
    logic unused_flags;
    assign unused_flags = zero_q ^ neg_q;
`endif
endmodule
